// File: rtl/rtc_ts_capture_if.sv
// Read-side bus of the timestamp capture unit.
//
// The slave side (rtc_ts_capture) presents the FIFO head and status. The
// master side (host or packet logic) drains entries and clears overflow.
//
// Signals:
//   rd_pop   master->slave  pop the head entry, one per cycle while high
//   ovf_clr  master->slave  clear the sticky overflow flag
//   rd_valid slave->master  FIFO non-empty, head is on rd_ns/rd_sec
//   rd_ns    slave->master  head ns: [37:8] integer ns, [7:0] fraction
//   rd_sec   slave->master  head seconds
//   fifo_cnt slave->master  number of stored entries
//   ovf      slave->master  sticky, a capture was dropped on a full FIFO
interface rtc_ts_capture_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          rd_pop;
    logic          ovf_clr;
    logic          rd_valid;
    logic [37:0]   rd_ns;
    logic [47:0]   rd_sec;
    logic [CW-1:0] fifo_cnt;
    logic          ovf;

    modport master (
        output rd_pop, ovf_clr,
        input  rd_valid, rd_ns, rd_sec, fifo_cnt, ovf
    );

    modport slave (
        input  rd_pop, ovf_clr,
        output rd_valid, rd_ns, rd_sec, fifo_cnt, ovf
    );
endinterface

// File: rtl/rtc_ts_capture.sv
// Timestamp capture unit sitting beside the RTC.
//
// Each rising edge of the asynchronous evt_in (while cap_en is set) samples
// the RTC time of day, subtracts a fixed pipeline compensation in ns (with
// a borrow from the seconds field when needed) and queues the result in a
// small first-word-fall-through FIFO drained through the rd interface.
//
// Ports:
//   clk          clock, same as the RTC
//   rst          asynchronous active-high reset
//   time_reg_ns  RTC ns: [37:8] integer ns, [7:0] fraction
//   time_reg_sec RTC seconds
//   evt_in       asynchronous event, rising edge requests a capture
//   cap_en       synchronous capture enable
//   rd           read-side interface (slave modport)
module rtc_ts_capture #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int COMP_NS     = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [37:0]            time_reg_ns,
    input  logic [47:0]            time_reg_sec,
    input  logic                   evt_in,
    input  logic                   cap_en,
    rtc_ts_capture_if.slave        rd
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [30:0] COMP    = 31'(COMP_NS);
    localparam logic [30:0] BILLION = 31'd1_000_000_000;

    logic [SYNC_STAGES-1:0] sync;
    logic                   evt_s;
    logic                   evt_d;
    logic                   evt_edge;

    logic                   cap_vld;
    logic [37:0]            cap_ns;
    logic [47:0]            cap_sec;

    logic [30:0]            n_ext;
    logic                   borrow;
    logic [29:0]            ns_adj;
    logic [47:0]            sec_adj;

    logic                   cmp_vld;
    logic [37:0]            cmp_ns;
    logic [47:0]            cmp_sec;

    logic [85:0]            mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          cnt;
    logic                   full;
    logic                   do_pop;
    logic                   do_write;
    logic                   drop;
    logic                   ovf;
    logic [85:0]            head;

    assign evt_s    = sync[SYNC_STAGES-1];
    // Edge detection runs regardless of cap_en, so a level that is already
    // high when capture gets enabled never looks like a fresh edge.
    assign evt_edge = evt_s & ~evt_d;

    // Synchronizer chain and edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            evt_d <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], evt_in};
            evt_d <= evt_s;
        end
    end

    // Stage A: snapshot the RTC on a qualified edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_vld <= 1'b0;
            cap_ns  <= '0;
            cap_sec <= '0;
        end else begin
            cap_vld <= evt_edge & cap_en;
            if (evt_edge & cap_en) begin
                cap_ns  <= time_reg_ns;
                cap_sec <= time_reg_sec;
            end
        end
    end

    // Compensation arithmetic is done in 31 bits so that n + 1e9 cannot wrap
    // before COMP is subtracted; the result always fits back in 30 bits.
    assign n_ext   = {1'b0, cap_ns[37:8]};
    assign borrow  = n_ext < COMP;
    assign ns_adj  = borrow ? 30'(n_ext + BILLION - COMP) : 30'(n_ext - COMP);
    assign sec_adj = borrow ? cap_sec - 48'd1 : cap_sec;

    // Stage B: register the compensated timestamp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_vld <= 1'b0;
            cmp_ns  <= '0;
            cmp_sec <= '0;
        end else begin
            cmp_vld <= cap_vld;
            if (cap_vld) begin
                cmp_ns  <= {ns_adj, cap_ns[7:0]};
                cmp_sec <= sec_adj;
            end
        end
    end

    // A push on a full FIFO still succeeds if the head leaves the same cycle.
    assign full     = (cnt == CW'(DEPTH));
    assign do_pop   = rd.rd_pop && (cnt != '0);
    assign do_write = cmp_vld && (!full || do_pop);
    assign drop     = cmp_vld && full && !do_pop;

    // FIFO storage; not reset because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= {cmp_sec, cmp_ns};
        end
    end

    // Pointers, occupancy and the sticky overflow flag (set beats clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_write && !do_pop) begin
                cnt <= cnt + CW'(1);
            end else if (!do_write && do_pop) begin
                cnt <= cnt - CW'(1);
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (rd.ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign head        = mem[rd_ptr];
    assign rd.rd_valid = (cnt != '0);
    assign rd.rd_ns    = rd.rd_valid ? head[37:0]  : '0;
    assign rd.rd_sec   = rd.rd_valid ? head[85:38] : '0;
    assign rd.fifo_cnt = cnt;
    assign rd.ovf      = ovf;

endmodule

// File: tb/tb_rtc_ts_capture.sv
// Self-checking bench for rtc_ts_capture.
//
// Two instances share clock, reset, RTC time and event inputs: one with no
// compensation and one with COMP_NS=16, so every capture is checked both raw
// and with the ns borrow applied. All inputs change just after a falling
// edge and outputs are sampled there too.
module tb_rtc_ts_capture;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [37:0] time_reg_ns;
    logic [47:0] time_reg_sec;
    logic        evt_in;
    logic        cap_en;
    logic        pop;
    logic        clr;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [47:0] sec;
        logic [29:0] ns;
    } ts_t;
    ts_t expq[$];

    rtc_ts_capture_if #(.DEPTH(DEPTH)) if0 ();
    rtc_ts_capture_if #(.DEPTH(DEPTH)) if16 ();

    assign if0.rd_pop   = pop;
    assign if0.ovf_clr  = clr;
    assign if16.rd_pop  = pop;
    assign if16.ovf_clr = clr;

    rtc_ts_capture #(.DEPTH(DEPTH), .SYNC_STAGES(2), .COMP_NS(0)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .time_reg_ns  (time_reg_ns),
        .time_reg_sec (time_reg_sec),
        .evt_in       (evt_in),
        .cap_en       (cap_en),
        .rd           (if0.slave)
    );

    rtc_ts_capture #(.DEPTH(DEPTH), .SYNC_STAGES(2), .COMP_NS(16)) dut16 (
        .clk          (clk),
        .rst          (rst),
        .time_reg_ns  (time_reg_ns),
        .time_reg_sec (time_reg_sec),
        .evt_in       (evt_in),
        .cap_en       (cap_en),
        .rd           (if16.slave)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One event pulse with the RTC held steady until the sample edge.
    // Called and returning just after a falling edge; the entry lands in the
    // FIFO two cycles after return.
    task automatic applyStimulus(input logic [47:0] sec, input logic [29:0] ns,
                                 input logic [7:0] frac);
        time_reg_sec = sec;
        time_reg_ns  = {ns, frac};
        evt_in       = 1'b1;
        @(negedge clk);
        evt_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Compare head of both instances against the expected queue, then pop.
    task automatic popCheck(input string tag);
        ts_t e;
        e = expq.pop_front();
        checkOutput({tag, "_vld0"},  64'(if0.rd_valid), 64'd1);
        checkOutput({tag, "_sec0"},  64'(if0.rd_sec),   64'(e.sec));
        checkOutput({tag, "_ns0"},   64'(if0.rd_ns),    64'({e.ns, 8'h00}));
        checkOutput({tag, "_sec16"}, 64'(if16.rd_sec),  64'(e.sec));
        checkOutput({tag, "_ns16"},  64'(if16.rd_ns),   64'({e.ns - 30'd16, 8'h00}));
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
    endtask

    task automatic queueEvent(input logic [47:0] sec, input logic [29:0] ns);
        ts_t e;
        e.sec = sec;
        e.ns  = ns;
        expq.push_back(e);
        applyStimulus(sec, ns, 8'h00);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        time_reg_ns  = '0;
        time_reg_sec = '0;
        evt_in       = 1'b0;
        cap_en       = 1'b0;
        pop          = 1'b0;
        clr          = 1'b0;
        waitCycles(2);

        // Reset values.
        checkOutput("rst_vld",  64'(if0.rd_valid), 64'd0);
        checkOutput("rst_cnt",  64'(if0.fifo_cnt), 64'd0);
        checkOutput("rst_ovf",  64'(if0.ovf),      64'd0);
        checkOutput("rst_ns",   64'(if0.rd_ns),    64'd0);
        checkOutput("rst_sec",  64'(if0.rd_sec),   64'd0);
        rst    = 1'b0;
        cap_en = 1'b1;
        waitCycles(2);

        // Single capture with latency and fraction passthrough.
        applyStimulus(48'd10, 30'd100, 8'h5A);
        checkOutput("lat_k2",   64'(if0.rd_valid), 64'd0);
        waitCycles(1);
        checkOutput("lat_k3",   64'(if0.rd_valid), 64'd0);
        waitCycles(1);
        checkOutput("lat_k4",   64'(if0.rd_valid), 64'd1);
        checkOutput("one_sec0", 64'(if0.rd_sec),   64'd10);
        checkOutput("one_ns0",  64'(if0.rd_ns),    64'({30'd100, 8'h5A}));
        checkOutput("one_sec16",64'(if16.rd_sec),  64'd10);
        checkOutput("one_ns16", 64'(if16.rd_ns),   64'({30'd84, 8'h5A}));
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        checkOutput("one_pop_vld", 64'(if0.rd_valid), 64'd0);
        checkOutput("one_pop_cnt", 64'(if16.fifo_cnt), 64'd0);

        // Second borrow cases and the exact-boundary case.
        applyStimulus(48'd10, 30'd8, 8'h00);
        waitCycles(2);
        checkOutput("brw_sec0",  64'(if0.rd_sec),  64'd10);
        checkOutput("brw_ns0",   64'(if0.rd_ns),   64'({30'd8, 8'h00}));
        checkOutput("brw_sec16", 64'(if16.rd_sec), 64'd9);
        checkOutput("brw_ns16",  64'(if16.rd_ns),  64'({30'd999_999_992, 8'h00}));
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        applyStimulus(48'd0, 30'd0, 8'h00);
        waitCycles(2);
        checkOutput("wrap_sec16", 64'(if16.rd_sec), 64'hFFFF_FFFF_FFFF);
        checkOutput("wrap_ns16",  64'(if16.rd_ns),  64'({30'd999_999_984, 8'h00}));
        checkOutput("wrap_sec0",  64'(if0.rd_sec),  64'd0);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        applyStimulus(48'd5, 30'd16, 8'h00);
        waitCycles(2);
        checkOutput("eq_sec16", 64'(if16.rd_sec), 64'd5);
        checkOutput("eq_ns16",  64'(if16.rd_ns),  64'd0);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;

        // Overflow: five events, four kept in order.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                queueEvent(48'(100 + i), 30'(1000 + i * 100));
            end else begin
                applyStimulus(48'd104, 30'd1400, 8'h00);
            end
        end
        waitCycles(2);
        checkOutput("ovf_cnt0",  64'(if0.fifo_cnt),  64'd4);
        checkOutput("ovf_flag0", 64'(if0.ovf),       64'd1);
        checkOutput("ovf_flag16",64'(if16.ovf),      64'd1);
        for (int i = 0; i < 4; i++) popCheck($sformatf("ovf_pop%0d", i));
        checkOutput("ovf_empty", 64'(if0.rd_valid), 64'd0);
        checkOutput("ovf_hold",  64'(if0.ovf),      64'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checkOutput("ovf_clr", 64'(if0.ovf), 64'd0);

        // Drop concurrent with clear: set wins.
        for (int i = 0; i < 4; i++) queueEvent(48'(200 + i), 30'(2000 + i * 100));
        applyStimulus(48'd299, 30'd9000, 8'h00);
        waitCycles(1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checkOutput("setwin_ovf0",  64'(if0.ovf),      64'd1);
        checkOutput("setwin_ovf16", 64'(if16.ovf),     64'd1);
        checkOutput("setwin_cnt",   64'(if0.fifo_cnt), 64'd4);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;

        // Full FIFO with push and pop on the same edge.
        applyStimulus(48'd300, 30'd3000, 8'h00);
        waitCycles(1);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        void'(expq.pop_front());
        expq.push_back('{sec: 48'd300, ns: 30'd3000});
        checkOutput("pp_cnt", 64'(if0.fifo_cnt), 64'd4);
        checkOutput("pp_ovf", 64'(if0.ovf),      64'd0);
        for (int i = 0; i < 4; i++) popCheck($sformatf("pp_pop%0d", i));

        // Pop on empty is ignored.
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        checkOutput("epop_cnt", 64'(if0.fifo_cnt), 64'd0);
        checkOutput("epop_vld", 64'(if0.rd_valid), 64'd0);
        queueEvent(48'd400, 30'd4000);
        waitCycles(2);
        checkOutput("epop_cnt1", 64'(if0.fifo_cnt), 64'd1);
        popCheck("epop_after");

        // Enable gating: a held level is not an edge.
        cap_en       = 1'b0;
        time_reg_sec = 48'd500;
        time_reg_ns  = {30'd5000, 8'h00};
        evt_in       = 1'b1;
        waitCycles(4);
        cap_en = 1'b1;
        waitCycles(6);
        checkOutput("gate_cnt0",  64'(if0.fifo_cnt),  64'd0);
        checkOutput("gate_cnt16", 64'(if16.fifo_cnt), 64'd0);
        evt_in = 1'b0;
        waitCycles(3);
        queueEvent(48'd501, 30'd5100);
        waitCycles(2);
        checkOutput("gate_one", 64'(if0.fifo_cnt), 64'd1);
        popCheck("gate_pop");
        waitCycles(4);
        checkOutput("gate_none", 64'(if0.fifo_cnt), 64'd0);

        // Reset mid-stream with a full FIFO, ovf set and a capture in flight.
        for (int i = 0; i < 5; i++) applyStimulus(48'(600 + i), 30'(6000 + i), 8'h00);
        waitCycles(2);
        expq.delete();
        evt_in = 1'b1;
        @(negedge clk);
        evt_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("mrst_vld",   64'(if0.rd_valid), 64'd0);
        checkOutput("mrst_cnt",   64'(if0.fifo_cnt), 64'd0);
        checkOutput("mrst_ovf",   64'(if0.ovf),      64'd0);
        checkOutput("mrst_sec",   64'(if0.rd_sec),   64'd0);
        checkOutput("mrst_cnt16", 64'(if16.fifo_cnt),64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        waitCycles(8);
        checkOutput("post_cnt", 64'(if0.fifo_cnt), 64'd0);
        checkOutput("post_vld", 64'(if16.rd_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/rtc_ts_capture.md
# rtc_ts_capture

Timestamp capture unit that reads the `rtc` time-of-day outputs (`time_reg_sec`, `time_reg_ns`) on each rising edge of an asynchronous event input (PPS, SFD strobe, GPIO). Each captured timestamp is latency-compensated and queued in a small first-word-fall-through FIFO, which host or packet logic drains with a pop strobe. It sits beside `rtc` in the same clock domain as the reader counterpart of the RTC's time load path.

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `SYNC_STAGES`, 2: synchronizer flops on `evt_in`; at least 2.
- `COMP_NS`, 0: integer ns subtracted from each capture to cancel the pipeline delay; 0 ≤ `COMP_NS` < 1_000_000_000.

Ports:
- `clk` in 1: clock, same clock as `rtc`.
- `rst` in 1: reset, asynchronous, active-high.
- `time_reg_ns` in 38: RTC ns; [37:8] integer ns (0..999_999_999), [7:0] ns fraction.
- `time_reg_sec` in 48: RTC seconds.
- `evt_in` in 1: asynchronous event; rising edge = capture request.
- `cap_en` in 1: capture enable, synchronous.
- `rd_pop` in 1: pop the head entry; one entry per cycle while high.
- `rd_valid` out 1: FIFO non-empty; head is on `rd_ns`/`rd_sec`.
- `rd_ns` out 38: head timestamp ns, same format as `time_reg_ns`.
- `rd_sec` out 48: head timestamp seconds.
- `fifo_cnt` out log2(DEPTH)+1: number of stored entries.
- `ovf` out 1: sticky; a capture was dropped because the FIFO was full.
- `ovf_clr` in 1: clears `ovf`.

## Operation

- **Synchronizer:** chain `s[0..SYNC_STAGES-1]` with `s[0] <= evt_in`. `evt_s` = last stage. `evt_d <= evt_s`.
- **Edge detect:** `edge = evt_s & ~evt_d`.
  - The edge detector tracks `evt_s` whether or not `cap_en` is set.
  - A level already high when `cap_en` rises is never captured.
- **Stage A:** on a clock where `edge & cap_en` is high, latch `time_reg_ns` and `time_reg_sec` into capture registers and set `capA_vld` for one cycle.
- **Stage B (compensation, registered):**
  - Let `n` = captured [37:8].
  - If `n >= COMP_NS`: ns_int = `n - COMP_NS`; sec unchanged.
  - Otherwise: ns_int = `n + 1_000_000_000 - COMP_NS` and sec = sec − 1, modulo 2^48 (0 becomes 2^48−1).
  - The fraction [7:0] passes through unchanged.
  - The stage B result is written to the FIFO on the following edge.
- **FIFO:** circular buffer with write and read pointers and a count. Head entry is presented combinationally from storage.
  - Push only: count +1. Pop only while non-empty: count −1.
  - Push and pop in the same cycle (including when full): both happen; count unchanged; no overflow.
  - Pop while empty: ignored; no underflow, pointers unchanged.
  - Push while full with no pop: entry dropped, `ovf` set, contents unchanged.
- **`ovf`:** cleared by `ovf_clr`. If a drop and `ovf_clr` occur in the same cycle, set wins and `ovf` stays 1.
- **Back-to-back edges:** the pipeline accepts a new capture every cycle. Captures never merge.
- **Reset, including mid-operation:** all synchronizer flops, `evt_d`, the pipeline valids, pointers, `fifo_cnt`, `ovf`, and the capture registers clear to 0. Any capture in flight is discarded.

## Timing

- **Reset values:** `rd_valid`=0, `fifo_cnt`=0, `ovf`=0, `rd_ns`=0, `rd_sec`=0.
- **Capture latency:** `evt_in` is first seen high at clock edge k.
  - `evt_s`=1 after edge k+SYNC_STAGES−1.
  - The time sampled is the RTC value present just before edge k+SYNC_STAGES.
  - Stage B registers at edge k+SYNC_STAGES+1.
  - The FIFO write occurs at edge k+SYNC_STAGES+2; `rd_valid` is high after it.
- **Pop:** `rd_pop` is sampled at the clock edge. The next entry, or `rd_valid`=0, is visible in the following cycle.
- **Worked example:** RTC stepping 8 ns per clock, `SYNC_STAGES`=2. The sample is 2 edges after `evt_in`, so `COMP_NS`=16 cancels the synchronizer delay to within one clock.

## Test plan

- **Reset:** assert `rst` mid-stream with 2 entries queued -> `rd_valid`=0, `fifo_cnt`=0, `ovf`=0 immediately; no stale entry after release.
- **Single capture:** `COMP_NS`=0, RTC reads sec=10, ns[37:8]=100, frac=8'h5A at the sample edge -> one entry rd_sec=10, rd_ns[37:8]=100, rd_ns[7:0]=8'h5A; `rd_valid` rises SYNC_STAGES+2 edges after `evt_in`; pop -> `rd_valid`=0.
- **Second borrow:** `COMP_NS`=16, sampled sec=10, ns=8 -> rd_sec=9, rd_ns[37:8]=999_999_992. Sampled sec=0, ns=0 -> rd_sec=2^48−1, rd_ns[37:8]=999_999_984.
- **Overflow:** `DEPTH`=4, 5 events with no pops -> `fifo_cnt`=4, `ovf`=1; pops return the first 4 timestamps in order. `ovf_clr` then clears `ovf`; a drop concurrent with `ovf_clr` leaves `ovf`=1.
- **Full with push and pop:** FIFO full, capture arrives on the same cycle as `rd_pop` -> `fifo_cnt` stays 4, `ovf`=0, newest entry is at the tail. `rd_pop` on an empty FIFO -> no change.
- **Enable gating:** `evt_in` rises while `cap_en`=0 and stays high, then `cap_en`=1 -> no capture. Next a low-then-high pulse -> exactly one capture.
